data_mem_dump_reader: RTL

//  Debug-side reader for the data memory debug port. While the pipeline is halted, walks every

---
 rtl/dump_pkg.sv | 13 +
 rtl/word_byte_serializer.sv | 68 ++++++
 rtl/data_mem_dump_reader.sv | 126 ++++++++++++
 3 files changed

// File: rtl/dump_pkg.sv
// Shared constants for the data-memory dump reader: FSM state encodings and word geometry.
package dump_pkg;

    localparam int BYTES_PER_WORD = 4;
    localparam int BYTE_IDX_W     = $clog2(BYTES_PER_WORD);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_FETCH = 3'd1;
    localparam logic [2:0] ST_SEND  = 3'd2;
    localparam logic [2:0] ST_CKSUM = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

endpackage

// File: rtl/word_byte_serializer.sv
// Holds one captured memory word and presents it MSB-byte-first on a valid/ready byte port.
// A single extra byte (e.g. a checksum) can be loaded as if it were the last byte of a word.
module word_byte_serializer
    import dump_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                             i_clk,
    input  logic                             i_reset_n,
    input  logic                             i_clear,
    input  logic                             i_load_word,
    input  logic [DATA_WIDTH*BYTES_PER_WORD-1:0] i_word,
    input  logic                             i_load_byte,
    input  logic [DATA_WIDTH-1:0]            i_byte,
    input  logic                             i_tx_ready,
    output logic [DATA_WIDTH-1:0]            o_tx_data,
    output logic                             o_tx_valid,
    output logic                             o_last
);

    localparam logic [BYTE_IDX_W-1:0] LAST_IDX = BYTE_IDX_W'(BYTES_PER_WORD - 1);

    logic [DATA_WIDTH*BYTES_PER_WORD-1:0] r_word;
    logic [BYTE_IDX_W-1:0]                r_idx;
    logic [BYTE_IDX_W-1:0]                w_idx_next;
    logic [DATA_WIDTH-1:0]                w_bytes [BYTES_PER_WORD];
    logic                                 w_accept;

    // Byte 0 is the most significant byte of the word.
    generate
        for (genvar gi = 0; gi < BYTES_PER_WORD; gi++) begin : g_bytes
            assign w_bytes[gi] = r_word[(BYTES_PER_WORD-1-gi)*DATA_WIDTH +: DATA_WIDTH];
        end
    endgenerate

    assign w_accept   = o_tx_valid & i_tx_ready;
    assign w_idx_next = r_idx + BYTE_IDX_W'(1);
    assign o_last     = w_accept & (r_idx == LAST_IDX);

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_word     <= '0;
            r_idx      <= '0;
            o_tx_data  <= '0;
            o_tx_valid <= 1'b0;
        end else if (i_clear) begin
            r_idx      <= '0;
            o_tx_valid <= 1'b0;
        end else if (i_load_word) begin
            r_word     <= i_word;
            r_idx      <= '0;
            o_tx_data  <= i_word[(BYTES_PER_WORD-1)*DATA_WIDTH +: DATA_WIDTH];
            o_tx_valid <= 1'b1;
        end else if (i_load_byte) begin
            r_idx      <= LAST_IDX;
            o_tx_data  <= i_byte;
            o_tx_valid <= 1'b1;
        end else if (w_accept) begin
            if (r_idx == LAST_IDX) begin
                o_tx_valid <= 1'b0;
            end else begin
                r_idx     <= w_idx_next;
                o_tx_data <= w_bytes[w_idx_next];
            end
        end
    end

endmodule

// File: rtl/data_mem_dump_reader.sv
// Walks all of data memory while the pipeline is halted and streams it out byte by byte.
// Define DUMP_CHECKSUM_EN to append one XOR-of-all-bytes checksum byte after the last word.
module data_mem_dump_reader
    import dump_pkg::*;
#(
    parameter int DATA_WIDTH     = 8,
    parameter int MEM_ADDR_WIDTH = 8
) (
    input  logic                        i_clk,
    input  logic                        i_reset_n,
    input  logic                        i_halt,
    input  logic                        i_start,
    output logic [MEM_ADDR_WIDTH-1:0]   o_mem_addr,
    input  logic [DATA_WIDTH*4-1:0]     i_mem_data,
    output logic [DATA_WIDTH-1:0]       o_tx_data,
    output logic                        o_tx_valid,
    input  logic                        i_tx_ready,
    output logic                        o_busy,
    output logic                        o_done
);

    localparam logic [MEM_ADDR_WIDTH-1:0] LAST_ADDR = {{(MEM_ADDR_WIDTH-2){1'b1}}, 2'b00};
    localparam logic [MEM_ADDR_WIDTH-1:0] ADDR_STEP = MEM_ADDR_WIDTH'(BYTES_PER_WORD);

    logic [2:0]                r_state;
    logic [MEM_ADDR_WIDTH-1:0] r_addr;
    logic                      w_abort;
    logic                      w_load_word;
    logic                      w_load_byte;
    logic [DATA_WIDTH-1:0]     w_cksum;
    logic                      w_last;
    logic                      w_last_word;

    assign o_mem_addr  = r_addr;
    assign o_busy      = (r_state != ST_IDLE);
    assign o_done      = (r_state == ST_DONE);
    assign w_abort     = (r_state != ST_IDLE) & ~i_halt;
    assign w_load_word = (r_state == ST_FETCH) & ~w_abort;
    assign w_last_word = (r_addr == LAST_ADDR);

`ifdef DUMP_CHECKSUM_EN
    logic [DATA_WIDTH-1:0] r_xor;

    // The checksum must include the byte being accepted on the same edge it is loaded.
    assign w_cksum     = r_xor ^ o_tx_data;
    assign w_load_byte = (r_state == ST_SEND) & w_last & w_last_word & ~w_abort;

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_xor <= '0;
        end else if (r_state == ST_IDLE) begin
            r_xor <= '0;
        end else if ((r_state == ST_SEND) && o_tx_valid && i_tx_ready) begin
            r_xor <= r_xor ^ o_tx_data;
        end
    end
`else
    assign w_cksum     = '0;
    assign w_load_byte = 1'b0;
`endif

    word_byte_serializer #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_serializer (
        .i_clk       (i_clk),
        .i_reset_n   (i_reset_n),
        .i_clear     (w_abort),
        .i_load_word (w_load_word),
        .i_word      (i_mem_data),
        .i_load_byte (w_load_byte),
        .i_byte      (w_cksum),
        .i_tx_ready  (i_tx_ready),
        .o_tx_data   (o_tx_data),
        .o_tx_valid  (o_tx_valid),
        .o_last      (w_last)
    );

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_state <= ST_IDLE;
            r_addr  <= '0;
        end else if (w_abort) begin
            r_state <= ST_IDLE;
            r_addr  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_start && i_halt) begin
                        r_state <= ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    r_state <= ST_SEND;
                end
                ST_SEND: begin
                    if (w_last) begin
                        if (w_last_word) begin
`ifdef DUMP_CHECKSUM_EN
                            r_state <= ST_CKSUM;
`else
                            r_state <= ST_DONE;
`endif
                        end else begin
                            r_addr  <= r_addr + ADDR_STEP;
                            r_state <= ST_FETCH;
                        end
                    end
                end
                ST_CKSUM: begin
                    if (w_last) begin
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                    r_addr  <= '0;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_addr  <= '0;
                end
            endcase
        end
    end

endmodule
